// File: rtl/uart_verici_param_if.sv
// Byte handshake into the UART transmitter FIFO.
// Latency: none, wires only.
// Backpressure: veri_hazir low means the FIFO is full and the word is held.
interface uart_verici_param_if;
    logic [7:0] veri;
    logic       veri_gecerli;
    logic       veri_hazir;

    modport master (output veri, output veri_gecerli, input veri_hazir);
    modport slave  (input veri, input veri_gecerli, output veri_hazir);
endinterface

// File: rtl/uart_verici_param.sv
// FIFO-buffered UART transmitter with runtime data length, parity and stop bits.
// Latency: word accepted at edge E0 into an idle, empty block drives the start bit from E1.
// Backpressure: veri_hazir drops while the FIFO is full; pushes are refused even on a same-cycle pop.
module uart_verici_param #(
    parameter int FIFO_DERINLIK = 8,
    parameter int BAUD_GENISLIK = 16
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    uart_verici_param_if.slave               giris,
    input  logic [BAUD_GENISLIK-1:0]         baud_div_i,
    input  logic [1:0]                       veri_bit_i,
    input  logic [1:0]                       parite_i,
    input  logic                             dur_bit_i,
    output logic                             tx_o,
    output logic                             mesgul_o,
    output logic                             fifo_dolu_o,
    output logic                             fifo_bos_o,
    output logic [$clog2(FIFO_DERINLIK):0]   fifo_sayac_o
);
    localparam int AW = $clog2(FIFO_DERINLIK);

    typedef enum logic [2:0] {BOSTA, BASLA, VERI, PARITE, DUR} durum_t;

    logic [7:0]               mem [FIFO_DERINLIK];
    logic [AW-1:0]            yaz_ptr, oku_ptr;
    logic [AW:0]              sayac_q;
    logic                     yaz, oku;

    durum_t                   durum_q, durum_d;
    logic [7:0]               kaydirici;
    logic [BAUD_GENISLIK-1:0] baud_sayac, cfg_son, baud_son_d;
    logic [1:0]               cfg_bit, cfg_par;
    logic                     cfg_dur;
    logic [2:0]               bit_idx;
    logic                     dur_idx;
    logic                     parite_q;
    logic                     tx_q, mesgul_q;
    logic                     bit_son, son_veri, son_dur, parite_var;

    // Full/empty decode straight from the occupancy register.
    assign fifo_dolu_o  = (sayac_q == (AW+1)'(FIFO_DERINLIK));
    assign fifo_bos_o   = (sayac_q == '0);
    assign fifo_sayac_o = sayac_q;
    assign giris.veri_hazir = !fifo_dolu_o;
    assign tx_o         = tx_q;
    assign mesgul_o     = mesgul_q;

    assign yaz = giris.veri_gecerli && !fifo_dolu_o;

    always_ff @(posedge clk_i) begin
        if (yaz) mem[yaz_ptr] <= giris.veri;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayac_q <= '0;
        end else begin
            if (yaz) yaz_ptr <= yaz_ptr + 1'b1;
            if (oku) oku_ptr <= oku_ptr + 1'b1;
            case ({yaz, oku})
                2'b10:   sayac_q <= sayac_q + 1'b1;
                2'b01:   sayac_q <= sayac_q - 1'b1;
                default: sayac_q <= sayac_q;
            endcase
        end
    end

    // A divider of 0 behaves as 1, so the terminal count is clamped at 0.
    assign baud_son_d = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
    assign bit_son    = (baud_sayac == cfg_son);
    assign son_veri   = (bit_idx == 3'd4 + {1'b0, cfg_bit});
    assign son_dur    = (dur_idx == cfg_dur);
    assign parite_var = (cfg_par == 2'd1) || (cfg_par == 2'd2);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) durum_q <= BOSTA;
        else         durum_q <= durum_d;
    end

    always_comb begin
        durum_d = durum_q;
        oku     = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (!fifo_bos_o) begin
                    oku     = 1'b1;
                    durum_d = BASLA;
                end
            end
            BASLA:  if (bit_son) durum_d = VERI;
            VERI:   if (bit_son && son_veri) durum_d = parite_var ? PARITE : DUR;
            PARITE: if (bit_son) durum_d = DUR;
            DUR: begin
                if (bit_son && son_dur) begin
                    if (!fifo_bos_o) begin
                        oku     = 1'b1;
                        durum_d = BASLA;
                    end else begin
                        durum_d = BOSTA;
                    end
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            kaydirici  <= '0;
            baud_sayac <= '0;
            cfg_son    <= '0;
            cfg_bit    <= '0;
            cfg_par    <= '0;
            cfg_dur    <= 1'b0;
            bit_idx    <= '0;
            dur_idx    <= 1'b0;
            parite_q   <= 1'b0;
            tx_q       <= 1'b1;
            mesgul_q   <= 1'b0;
        end else if (oku) begin
            kaydirici  <= mem[oku_ptr];
            cfg_son    <= baud_son_d;
            cfg_bit    <= veri_bit_i;
            cfg_par    <= parite_i;
            cfg_dur    <= dur_bit_i;
            baud_sayac <= '0;
            bit_idx    <= '0;
            dur_idx    <= 1'b0;
            parite_q   <= 1'b0;
            tx_q       <= 1'b0;
            mesgul_q   <= 1'b1;
        end else if (durum_q != BOSTA) begin
            if (bit_son) begin
                baud_sayac <= '0;
                case (durum_q)
                    BASLA: begin
                        tx_q      <= kaydirici[0];
                        parite_q  <= parite_q ^ kaydirici[0];
                        kaydirici <= kaydirici >> 1;
                    end
                    VERI: begin
                        if (son_veri) begin
                            // parite_q already covers all N data bits here; odd mode inverts it.
                            tx_q <= parite_var ? (parite_q ^ cfg_par[1]) : 1'b1;
                        end else begin
                            tx_q      <= kaydirici[0];
                            parite_q  <= parite_q ^ kaydirici[0];
                            kaydirici <= kaydirici >> 1;
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                    PARITE: tx_q <= 1'b1;
                    DUR: begin
                        tx_q <= 1'b1;
                        if (son_dur) mesgul_q <= 1'b0;
                        else         dur_idx  <= 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                baud_sayac <= baud_sayac + 1'b1;
            end
        end
    end
endmodule
